// File: rtl/crg_ctr_engine.sv
`default_nettype none
// ============================================================================
//  Module      : crg_ctr_engine
//  Description : Correlated random generator, counter-mode engine.
//                Shares one external AES encryption core across N_CH
//                channels. Channel c encrypts plaintexts 0..N_BLK-1 under
//                key (seed + c) mod 2^LEN. Each ciphertext leaves on a
//                valid/ready stream tagged with its channel and block index.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    N_CH   number of channels (1..16)
//    N_BLK  blocks per channel (1..16)
//    LEN    key / data width in bits
//  Ports
//    clk, rst            clock, asynchronous active-high reset
//    seed, seed_we       base key and its load strobe (honoured in IDLE only)
//    start               one-cycle run request (honoured in IDLE only)
//    busy, done          run in progress / one-cycle end-of-run pulse
//    aes_key, aes_krdy   key and key-load strobe to the AES core
//    aes_kvld            key expansion complete
//    aes_din, aes_drdy   plaintext and data strobe to the AES core
//    aes_dout, aes_dvld  ciphertext and its one-cycle valid
//    aes_bsy             AES core busy; no strobe is issued while high
//    out_data/ch/blk     result block and its tags
//    out_valid/ready     result stream handshake
//  Build option
//    CRG_XOR_SHARE_EN    when defined, channel N_CH-1 is not encrypted; its
//                        block b is the XOR of blocks b of all other
//                        channels, so the N_CH shares of each block XOR to 0.
// ============================================================================
module crg_ctr_engine #(
    parameter int N_CH  = 3,
    parameter int N_BLK = 2,
    parameter int LEN   = 128
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [LEN-1:0] seed,
    input  logic           seed_we,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [LEN-1:0] aes_key,
    output logic           aes_krdy,
    input  logic           aes_kvld,
    output logic [LEN-1:0] aes_din,
    output logic           aes_drdy,
    input  logic           aes_dvld,
    input  logic [LEN-1:0] aes_dout,
    input  logic           aes_bsy,
    output logic [LEN-1:0] out_data,
    output logic [3:0]     out_ch,
    output logic [3:0]     out_blk,
    output logic           out_valid,
    input  logic           out_ready
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] C_ST_IDLE  = 3'd0;
    localparam logic [2:0] C_ST_KEY   = 3'd1;
    localparam logic [2:0] C_ST_KWAIT = 3'd2;
    localparam logic [2:0] C_ST_DATA  = 3'd3;
    localparam logic [2:0] C_ST_DWAIT = 3'd4;
    localparam logic [2:0] C_ST_OUT   = 3'd5;
    localparam logic [2:0] C_ST_FIN   = 3'd6;

    localparam logic [3:0] C_LAST_CH  = 4'(N_CH - 1);
    localparam logic [3:0] C_LAST_BLK = 4'(N_BLK - 1);

`ifdef CRG_XOR_SHARE_EN
    localparam bit C_XOR_EN = 1'b1;
`else
    localparam bit C_XOR_EN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [2:0]     r_state;
    logic [2:0]     w_next_state;
    logic [LEN-1:0] r_seed;
    logic [3:0]     r_ch;
    logic [3:0]     r_blk;

    logic           w_last_blk;
    logic           w_last_ch;
    logic           w_in_share;       // current channel is the XOR share
    logic           w_next_is_share;  // channel after this one is the share
    logic           w_start_share;    // single-channel share run: no AES at all

    logic           w_start_acc;
    logic           w_key_fire;
    logic           w_data_fire;
    logic           w_capture;
    logic           w_hs;

    assign w_last_blk      = (r_blk == C_LAST_BLK);
    assign w_last_ch       = (r_ch == C_LAST_CH);
    assign w_in_share      = C_XOR_EN && w_last_ch;
    assign w_next_is_share = C_XOR_EN && ((r_ch + 4'd1) == C_LAST_CH);
    assign w_start_share   = C_XOR_EN && (N_CH == 1);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            C_ST_IDLE: begin
                if (start) begin
                    w_next_state = w_start_share ? C_ST_OUT : C_ST_KEY;
                end
            end
            C_ST_KEY: begin
                if (!aes_bsy) begin
                    w_next_state = C_ST_KWAIT;
                end
            end
            C_ST_KWAIT: begin
                if (aes_kvld) begin
                    w_next_state = C_ST_DATA;
                end
            end
            C_ST_DATA: begin
                if (!aes_bsy) begin
                    w_next_state = C_ST_DWAIT;
                end
            end
            C_ST_DWAIT: begin
                if (aes_dvld) begin
                    w_next_state = C_ST_OUT;
                end
            end
            C_ST_OUT: begin
                if (w_hs) begin
                    if (!w_last_blk) begin
                        // Share blocks come straight from the accumulator.
                        w_next_state = w_in_share ? C_ST_OUT : C_ST_DATA;
                    end else if (!w_last_ch) begin
                        w_next_state = w_next_is_share ? C_ST_OUT : C_ST_KEY;
                    end else begin
                        w_next_state = C_ST_FIN;
                    end
                end
            end
            C_ST_FIN: begin
                w_next_state = C_ST_IDLE;
            end
            default: begin
                w_next_state = C_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / event decode
    // ------------------------------------------------------------------
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        w_start_acc = 1'b0;
        w_key_fire  = 1'b0;
        w_data_fire = 1'b0;
        w_capture   = 1'b0;
        w_hs        = 1'b0;
        unique case (r_state)
            C_ST_IDLE: begin
                w_start_acc = start;
            end
            C_ST_KEY: begin
                busy       = 1'b1;
                w_key_fire = !aes_bsy;
            end
            C_ST_KWAIT: begin
                busy = 1'b1;
            end
            C_ST_DATA: begin
                busy        = 1'b1;
                w_data_fire = !aes_bsy;
            end
            C_ST_DWAIT: begin
                busy      = 1'b1;
                w_capture = aes_dvld;
            end
            C_ST_OUT: begin
                busy = 1'b1;
                w_hs = out_valid && out_ready;
            end
            C_ST_FIN: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // XOR share accumulator: one LEN-bit entry per block index
    // ------------------------------------------------------------------
`ifdef CRG_XOR_SHARE_EN
    logic [LEN-1:0] r_acc [N_BLK];
    logic [LEN-1:0] w_share_data;
    logic [3:0]     w_share_blk;

    // Block index of the share that is presented next: the following block
    // while already inside the share channel, otherwise block 0.
    assign w_share_blk = w_in_share ? (r_blk + 4'd1) : 4'd0;

    always_comb begin
        w_share_data = '0;
        for (int b = 0; b < N_BLK; b++) begin
            if (w_share_blk == 4'(b)) begin
                w_share_data = r_acc[b];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < N_BLK; b++) begin
                r_acc[b] <= '0;
            end
        end else if (w_start_acc) begin
            for (int b = 0; b < N_BLK; b++) begin
                r_acc[b] <= '0;
            end
        end else if (w_capture) begin
            for (int b = 0; b < N_BLK; b++) begin
                if (r_blk == 4'(b)) begin
                    r_acc[b] <= r_acc[b] ^ aes_dout;
                end
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Datapath: seed, counters, AES strobes and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seed    <= '0;
            r_ch      <= '0;
            r_blk     <= '0;
            aes_key   <= '0;
            aes_krdy  <= 1'b0;
            aes_din   <= '0;
            aes_drdy  <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_blk   <= '0;
            out_valid <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-fired below.
            aes_krdy <= 1'b0;
            aes_drdy <= 1'b0;
            unique case (r_state)
                C_ST_IDLE: begin
                    if (seed_we) begin
                        r_seed <= seed;
                    end
                    if (start) begin
                        r_ch  <= '0;
                        r_blk <= '0;
`ifdef CRG_XOR_SHARE_EN
                        // Lone share channel: every block is all-zero.
                        if (w_start_share) begin
                            out_data  <= '0;
                            out_ch    <= '0;
                            out_blk   <= '0;
                            out_valid <= 1'b1;
                        end
`endif
                    end
                end
                C_ST_KEY: begin
                    if (w_key_fire) begin
                        // Wraps modulo 2^LEN; the carry is discarded.
                        aes_key  <= r_seed + {{(LEN-4){1'b0}}, r_ch};
                        aes_krdy <= 1'b1;
                    end
                end
                C_ST_DATA: begin
                    if (w_data_fire) begin
                        aes_din  <= {{(LEN-4){1'b0}}, r_blk};
                        aes_drdy <= 1'b1;
                    end
                end
                C_ST_DWAIT: begin
                    if (w_capture) begin
                        out_data  <= aes_dout;
                        out_ch    <= r_ch;
                        out_blk   <= r_blk;
                        out_valid <= 1'b1;
                    end
                end
                C_ST_OUT: begin
                    if (w_hs) begin
                        out_valid <= 1'b0;
                        if (!w_last_blk) begin
                            r_blk <= r_blk + 4'd1;
`ifdef CRG_XOR_SHARE_EN
                            if (w_in_share) begin
                                out_data  <= w_share_data;
                                out_blk   <= r_blk + 4'd1;
                                out_valid <= 1'b1;
                            end
`endif
                        end else if (!w_last_ch) begin
                            r_ch  <= r_ch + 4'd1;
                            r_blk <= '0;
`ifdef CRG_XOR_SHARE_EN
                            if (w_next_is_share) begin
                                out_data  <= w_share_data;
                                out_ch    <= r_ch + 4'd1;
                                out_blk   <= '0;
                                out_valid <= 1'b1;
                            end
`endif
                        end
                    end
                end
                default: begin
                    // KWAIT and FIN only advance the state register.
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crg_ctr_engine.sv
`default_nettype none
module tb_crg_ctr_engine;

    localparam int N_CH  = 3;
    localparam int N_BLK = 2;
    localparam int LEN   = 128;
    localparam int N_OUT = N_CH * N_BLK;
    localparam logic [127:0] C_KAT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
`ifdef CRG_XOR_SHARE_EN
    localparam int N_AES_CH = N_CH - 1;
`else
    localparam int N_AES_CH = N_CH;
`endif

    logic           clk;
    logic           rst;
    logic [LEN-1:0] seed;
    logic           seed_we;
    logic           start;
    logic           busy;
    logic           done;
    logic [LEN-1:0] aes_key;
    logic           aes_krdy;
    logic           aes_kvld;
    logic [LEN-1:0] aes_din;
    logic           aes_drdy;
    logic           aes_dvld;
    logic [LEN-1:0] aes_dout;
    logic           aes_bsy;
    logic [LEN-1:0] out_data;
    logic [3:0]     out_ch;
    logic [3:0]     out_blk;
    logic           out_valid;
    logic           out_ready;

    crg_ctr_engine #(.N_CH(N_CH), .N_BLK(N_BLK), .LEN(LEN)) dut (
        .clk(clk), .rst(rst), .seed(seed), .seed_we(seed_we), .start(start),
        .busy(busy), .done(done), .aes_key(aes_key), .aes_krdy(aes_krdy),
        .aes_kvld(aes_kvld), .aes_din(aes_din), .aes_drdy(aes_drdy),
        .aes_dvld(aes_dvld), .aes_dout(aes_dout), .aes_bsy(aes_bsy),
        .out_data(out_data), .out_ch(out_ch), .out_blk(out_blk),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int vecs = 0;
    int errs = 0;

    typedef struct {
        logic [3:0]   ch;
        logic [3:0]   blk;
        logic [127:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [127:0] run_seed;
    logic [127:0] seed_model;
    int krdy_cnt = 0, drdy_cnt = 0, done_cnt = 0;
    int krdy_base = 0, drdy_base = 0, done_base = 0;
    logic [127:0] got [N_OUT];
    logic [127:0] xacc [N_BLK];
    logic [127:0] run_a_got [N_OUT];
    bit stray_req = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference AES-128 (FIPS-197), S-box built from GF(2^8) inverse
    // ------------------------------------------------------------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox;
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            end
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) s[k] = sbox_t[s[k]];
            for (int rr = 0; rr < 4; rr++)
                for (int c = 0; c < 4; c++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
            for (int c = 0; c < 4; c++) begin
                if (r != 10) begin
                    s[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
                    s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
                end else begin
                    for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*c+rr];
                end
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*r + k/4][31-8*(k%4) -: 8];
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
        return res;
    endfunction

    // Expected block for (ch, blk) given the base seed of the run.
    function automatic logic [127:0] ref_block(input logic [127:0] sd, input int ch, input int blk);
        logic [127:0] x;
`ifdef CRG_XOR_SHARE_EN
        if (ch == N_CH - 1) begin
            x = '0;
            for (int c = 0; c < N_CH - 1; c++) x = x ^ aes_enc(sd + 128'(c), 128'(blk));
            return x;
        end
`endif
        x = aes_enc(sd + 128'(ch), 128'(blk));
        return x;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural AES core: random key/data latency, random idle busy
    // ------------------------------------------------------------------
    initial begin
        logic [127:0] core_key, core_res;
        int kind, cnt;
        aes_bsy = 0; aes_kvld = 0; aes_dvld = 0; aes_dout = '0;
        core_key = '0; core_res = '0; kind = 0; cnt = 0;
        forever begin
            @(negedge clk);
            aes_kvld = 0;
            aes_dvld = 0;
            if (aes_krdy) begin
                core_key = aes_key; kind = 1; cnt = $urandom_range(1, 6); aes_bsy = 1;
            end else if (aes_drdy) begin
                core_res = aes_enc(core_key, aes_din); kind = 2; cnt = $urandom_range(1, 8); aes_bsy = 1;
            end else if (kind != 0) begin
                cnt--;
                if (cnt == 0) begin
                    if (kind == 1) aes_kvld = 1;
                    else begin aes_dvld = 1; aes_dout = core_res; end
                    kind = 0; aes_bsy = 0;
                end
            end else if (stray_req) begin
                aes_kvld = 1; aes_dvld = 1;
                aes_dout = {$urandom, $urandom, $urandom, $urandom};
                stray_req = 0;
            end else begin
                aes_bsy = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    logic         prev_stall = 0;
    logic         prev_done  = 0;
    logic [127:0] p_data;
    logic [3:0]   p_ch, p_blk;

    initial begin
        exp_t e;
        int idx;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 0; prev_done = 0;
                continue;
            end
            if (aes_krdy) begin
                check("aes_key", aes_key, run_seed + 128'(krdy_cnt - krdy_base));
                krdy_cnt++;
            end
            if (aes_drdy) begin
                check("aes_din", aes_din, 128'((drdy_cnt - drdy_base) % N_BLK));
                drdy_cnt++;
            end
            if (prev_stall) begin
                check("stall_data", out_data, p_data);
                check("stall_tag", {aes_drdy, out_valid, out_ch, out_blk}, {1'b0, 1'b1, p_ch, p_blk});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {out_ch, out_blk}, 128'hdead);
                end else begin
                    e = exp_q.pop_front();
                    check("out_tag", {out_ch, out_blk}, {e.ch, e.blk});
                    check("out_data", out_data, e.data);
                end
                idx = int'(out_ch) * N_BLK + int'(out_blk);
                if (idx < N_OUT && int'(out_blk) < N_BLK) begin
                    got[idx] = out_data;
                    xacc[out_blk] = xacc[out_blk] ^ out_data;
                end
            end
            if (done) begin
                done_cnt++;
                check("done_busy_low", {127'd0, busy}, 128'd0);
                check("done_single", {127'd0, prev_done}, 128'd0);
            end
            prev_done  = done;
            prev_stall = out_valid && !out_ready;
            p_data = out_data; p_ch = out_ch; p_blk = out_blk;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick;
        @(negedge clk);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic launch(input logic [127:0] s, input bit we);
        exp_t e;
        if (we) seed_model = s;
        run_seed  = seed_model;
        krdy_base = krdy_cnt; drdy_base = drdy_cnt; done_base = done_cnt;
        for (int b = 0; b < N_BLK; b++) xacc[b] = '0;
        for (int i = 0; i < N_OUT; i++) got[i] = '0;
        for (int c = 0; c < N_CH; c++)
            for (int b = 0; b < N_BLK; b++) begin
                e.ch = 4'(c); e.blk = 4'(b); e.data = ref_block(run_seed, c, b);
                exp_q.push_back(e);
            end
        seed = s; seed_we = we; start = 1;
        tick;
        seed_we = 0; start = 0; seed = rnd128();
        check("busy_after_start", {127'd0, busy}, 128'd1);
    endtask

    // mode 0: always ready, 1: random ready, 2: 20-cycle stall on first
    // block then random, 3: random ready plus start/seed_we while busy
    task automatic finish_run(input int mode);
        int cyc, stall_cnt;
        cyc = 0; stall_cnt = 0;
        while (done_cnt == done_base && cyc < 4000) begin
            case (mode)
                0: out_ready = 1;
                2: begin
                    if (stall_cnt <= 20) begin
                        out_ready = 0;
                        if (out_valid) begin
                            stall_cnt++;
                            if (stall_cnt == 5) stray_req = 1;
                        end
                    end else out_ready = ($urandom_range(0, 3) != 0);
                end
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (mode == 3 && cyc == 8) begin
                seed = ~run_seed; seed_we = 1; start = 1;
            end else begin
                seed_we = 0; start = 0;
            end
            cyc++;
            tick;
        end
        seed_we = 0; start = 0;
        if (cyc >= 4000) begin
            vecs++; errs++;
            $display("FAIL run_timeout: got no done within %0d cycles, expected done", cyc);
        end
        tick; tick; tick;
        check("done_count", 128'(done_cnt - done_base), 128'd1);
        check("queue_empty", 128'(exp_q.size()), 128'd0);
        check("krdy_count", 128'(krdy_cnt - krdy_base), 128'(N_AES_CH));
        check("drdy_count", 128'(drdy_cnt - drdy_base), 128'(N_AES_CH * N_BLK));
        check("idle_after_run", {busy, done, out_valid}, 128'd0);
`ifdef CRG_XOR_SHARE_EN
        for (int b = 0; b < N_BLK; b++) check("xor_shares_zero", xacc[b], 128'd0);
`endif
        exp_q.delete();
    endtask

    initial begin
        int cyc;
        rst = 1; seed = '0; seed_we = 0; start = 0; out_ready = 0;
        seed_model = '0; run_seed = '0;
        build_sbox();
        tick; tick; tick;
        check("rst_ctrl", {busy, done, aes_krdy, aes_drdy, out_valid, out_ch, out_blk}, 128'd0);
        check("rst_key", aes_key, 128'd0);
        check("rst_din", aes_din, 128'd0);
        check("rst_out_data", out_data, 128'd0);
        rst = 0;
        tick;

        // Seed 0, full throughput
        launch(128'd0, 1'b1);
        finish_run(0);
        check("kat_ch0_blk0", got[0], C_KAT);
        for (int i = 0; i < N_OUT; i++) run_a_got[i] = got[i];

        // Key wrap: channel 1 key is 0
        launch({128{1'b1}}, 1'b1);
        finish_run(1);
        check("wrap_ch1_blk0", got[N_BLK], C_KAT);

        // Long stall on the first block
        launch(rnd128(), 1'b1);
        finish_run(2);

        // start/seed_we during busy are ignored; next run keeps the old seed
        launch(rnd128(), 1'b1);
        finish_run(3);
        launch(rnd128(), 1'b0);
        finish_run(1);

        // Reset while waiting for ciphertext of (1,0)
        launch(128'd0, 1'b1);
        out_ready = 1;
        cyc = 0;
        while ((drdy_cnt - drdy_base) < N_BLK + 1 && cyc < 2000) begin
            cyc++;
            tick;
        end
        if (cyc >= 2000) begin
            vecs++; errs++;
            $display("FAIL reset_arm_timeout: got %0d drdy, expected %0d", drdy_cnt - drdy_base, N_BLK + 1);
        end
        rst = 1;
        #1;
        check("midrun_rst_ctrl", {busy, done, aes_krdy, aes_drdy, out_valid, out_ch, out_blk}, 128'd0);
        check("midrun_rst_data", {aes_key ^ aes_din ^ out_data}, 128'd0);
        check("midrun_rst_key", aes_key, 128'd0);
        exp_q.delete();
        tick; tick;
        rst = 0;
        seed_model = '0;
        tick;
        launch(rnd128(), 1'b0);
        finish_run(0);
        check("rerun_kat", got[0], C_KAT);
        for (int i = 0; i < N_OUT; i++) check("rerun_matches_first", got[i], run_a_got[i]);

        // Random runs, random backpressure, sometimes reusing the seed
        for (int r = 0; r < 3; r++) begin
            launch(rnd128(), 1'($urandom_range(0, 1)));
            finish_run(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
